// File: rtl/audio_spi_pkg.sv
// Shared definitions for the audio SPI configuration blocks: FSM state encoding and default sizing.
package audio_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP
    } spi_state_e;

    localparam int SPI_DATA_W_DEF  = 16;
    localparam int SPI_CLK_DIV_DEF = 2;

endpackage

// File: rtl/spi_master_baud.sv
// Half-period timer for the SPI master: while enabled, pulses tick on every CLK_DIV-th cycle.
module spi_master_baud #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master_cfg.sv
// SPI mode-0 master issuing one DATA_W-bit word per valid/ready command, MSB first.
// Define SPI_MASTER_CFG_READBACK_EN to capture the word returned on spi_miso into rsp_data.
module spi_master_cfg
    import audio_spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEF,
    parameter int DATA_W  = SPI_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              spi_ck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_nss
);

    localparam int BW = $clog2(DATA_W + 1);

    generate
        if (CLK_DIV < 1 || DATA_W < 2) begin : g_bad_params
            $error("spi_master_cfg: CLK_DIV must be >= 1 and DATA_W must be >= 2");
        end
    endgenerate

    spi_state_e        state, state_d;
    logic [DATA_W-1:0] tx_sr, tx_d;
    logic [BW-1:0]     bit_cnt, bit_d;
    logic              ck_q, ck_d;
    logic              mosi_q, mosi_d;
    logic              rsp_valid_q;
    logic              sample;
    logic              load_rsp;
    logic              tick;

    spi_master_baud #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .en  (state != ST_IDLE),
        .clr (state == ST_IDLE),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            tx_sr       <= '0;
            bit_cnt     <= '0;
            ck_q        <= 1'b0;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state       <= state_d;
            tx_sr       <= tx_d;
            bit_cnt     <= bit_d;
            ck_q        <= ck_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= load_rsp;
        end
    end

    // NOTE: every next-value signal is given its hold value first so no path through the case leaves it unassigned.
    always_comb begin
        state_d  = state;
        tx_d     = tx_sr;
        bit_d    = bit_cnt;
        ck_d     = ck_q;
        mosi_d   = mosi_q;
        sample   = 1'b0;
        load_rsp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_SETUP;
                    mosi_d  = cmd_data[DATA_W-1];
                    tx_d    = {cmd_data[DATA_W-2:0], 1'b0};
                    bit_d   = '0;
                    ck_d    = 1'b0;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                    ck_d    = 1'b1;
                    sample  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (ck_q) begin
                        // Falling edge: present the next bit and count the completed one.
                        ck_d   = 1'b0;
                        mosi_d = tx_sr[DATA_W-1];
                        tx_d   = {tx_sr[DATA_W-2:0], 1'b0};
                        bit_d  = bit_cnt + BW'(1);
                    end else if (bit_cnt == BW'(DATA_W)) begin
                        state_d  = ST_GAP;
                        mosi_d   = 1'b0;
                        bit_d    = '0;
                        load_rsp = 1'b1;
                    end else begin
                        ck_d   = 1'b1;
                        sample = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef SPI_MASTER_CFG_READBACK_EN
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] rsp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sr <= '0;
            rsp_q <= '0;
        end else begin
            if (sample) begin
                rx_sr <= {rx_sr[DATA_W-2:0], spi_miso};
            end
            if (load_rsp) begin
                rsp_q <= rx_sr;
            end
        end
    end

    assign rsp_data = rsp_q;
`else
    logic unused_miso;
    logic unused_sample;

    assign unused_miso   = spi_miso;
    assign unused_sample = sample;
    assign rsp_data      = '0;
`endif

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign spi_nss   = !(state == ST_SETUP || state == ST_SHIFT);
    assign spi_ck    = ck_q;
    assign spi_mosi  = mosi_q;
    assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Self-checking bench for spi_master_cfg: a 2/16 instance for the main vectors and corner sequences,
// and a 1/8 instance for the fast-divider case.
module tb_spi_master_cfg;

`ifdef SPI_MASTER_CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        c0_valid, c0_ready, r0_valid, b0, ck0, mosi0, miso0, nss0;
    logic [15:0] c0_data, r0_data;
    logic        c1_valid, c1_ready, r1_valid, b1, ck1, mosi1, miso1, nss1;
    logic [7:0]  c1_data, r1_data;

    spi_master_cfg #(.CLK_DIV(2), .DATA_W(16)) u0 (
        .clk(clk), .rst(rst), .cmd_valid(c0_valid), .cmd_ready(c0_ready), .cmd_data(c0_data),
        .rsp_valid(r0_valid), .rsp_data(r0_data), .busy(b0), .spi_ck(ck0), .spi_mosi(mosi0),
        .spi_miso(miso0), .spi_nss(nss0)
    );

    spi_master_cfg #(.CLK_DIV(1), .DATA_W(8)) u1 (
        .clk(clk), .rst(rst), .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_data(c1_data),
        .rsp_valid(r1_valid), .rsp_data(r1_data), .busy(b1), .spi_ck(ck1), .spi_mosi(mosi1),
        .spi_miso(miso1), .spi_nss(nss1)
    );

    typedef struct {
        int          nss_low;
        int          rises;
        int          pulses;
        int          bad_pulse;
        int          lat;
        int          ready_busy;
        logic [15:0] mosi_word;
        logic [15:0] rsp_word;
    } xfer_res_t;

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] miso;
        logic [15:0] exp_mosi;
        logic [15:0] exp_rsp;
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic set_valid(input int which, input logic v, input logic [15:0] d);
        if (which == 0) begin
            c0_valid = v;
            c0_data  = d;
        end else begin
            c1_valid = v;
            c1_data  = d[7:0];
        end
    endtask

    task automatic drive_miso(input int which, input logic b);
        if (which == 0) miso0 = b;
        else miso1 = b;
    endtask

    task automatic observe(input int which, output logic ck, output logic nss, output logic mosi,
                           output logic rv, output logic rdy, output logic [15:0] rd);
        if (which == 0) begin
            ck = ck0; nss = nss0; mosi = mosi0; rv = r0_valid; rdy = c0_ready; rd = r0_data;
        end else begin
            ck = ck1; nss = nss1; mosi = mosi1; rv = r1_valid; rdy = c1_ready; rd = {8'h00, r1_data};
        end
    endtask

    // One full transaction with a mode-0 slave model; optional one-cycle cmd_valid poke at cycle 'poke'.
    task automatic run_xfer(input int which, input logic [15:0] cmd, input logic [15:0] mword,
                            input int poke, output xfer_res_t r);
        int w;
        int idx;
        logic ck, nss, mosi, rv, rdy, pck, pnss;
        logic [15:0] rd;
        r = '{default: 0};
        w = (which == 0) ? 16 : 8;
        set_valid(which, 1'b1, cmd);
        @(posedge clk); #1;
        set_valid(which, 1'b0, cmd);
        pck  = 1'b0;
        pnss = 1'b1;
        idx  = 0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            observe(which, ck, nss, mosi, rv, rdy, rd);
            if (poke > 0 && cyc == poke) set_valid(which, 1'b1, ~cmd);
            else if (poke > 0 && cyc == poke + 1) set_valid(which, 1'b0, cmd);
            if (!nss) r.nss_low++;
            if (!nss && rdy) r.ready_busy++;
            if (ck && !pck) begin
                r.rises++;
                r.mosi_word = {r.mosi_word[14:0], mosi};
            end
            if (!nss && pnss) begin
                idx = 0;
                drive_miso(which, mword[w-1]);
            end else if (!ck && pck) begin
                idx++;
                drive_miso(which, (idx < w) ? mword[w-1-idx] : 1'b0);
            end
            if (rv) begin
                r.pulses++;
                r.rsp_word = rd;
                if (!(nss && !pnss)) r.bad_pulse++;
            end
            pck  = ck;
            pnss = nss;
            if (rdy) begin
                r.lat = cyc;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_xfer(input string tag, input xfer_res_t r, input int exp_low, input int exp_rises,
                              input int exp_lat, input logic [15:0] exp_mosi, input logic [15:0] exp_rsp);
        check({tag, "_nss_low"}, r.nss_low, exp_low);
        check({tag, "_rises"}, r.rises, exp_rises);
        check({tag, "_mosi"}, r.mosi_word, exp_mosi);
        check({tag, "_rsp_pulses"}, r.pulses, 1);
        check({tag, "_rsp_on_nss_rise"}, r.bad_pulse, 0);
        check({tag, "_rsp_data"}, r.rsp_word, exp_rsp);
        check({tag, "_latency"}, r.lat, exp_lat);
        check({tag, "_ready_while_busy"}, r.ready_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t      vecs[4];
        xfer_res_t r;
        int        seg, gap, rises, idle_hi, pulses;
        logic      pnss, pck, done, hit;
        logic [15:0] mw1, mw2;

        vecs[0] = '{16'hA55A, 16'h3C0F, 16'hA55A, RB ? 16'h3C0F : 16'h0000};
        vecs[1] = '{16'h0001, 16'hFFFF, 16'h0001, RB ? 16'hFFFF : 16'h0000};
        vecs[2] = '{16'h8000, 16'h0000, 16'h8000, 16'h0000};
        vecs[3] = '{16'hFFFF, 16'hA5A5, 16'hFFFF, RB ? 16'hA5A5 : 16'h0000};

        rst = 1'b1;
        c0_valid = 1'b0; c0_data = '0; miso0 = 1'b0;
        c1_valid = 1'b0; c1_data = '0; miso1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_u0", {c0_ready, r0_valid, (r0_data != 16'h0), b0, ck0, mosi0, nss0}, 7'b1000001);
        check("reset_u1", {c1_ready, r1_valid, (r1_data != 8'h0), b1, ck1, mosi1, nss1}, 7'b1000001);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", {c0_ready, b0, ck0, nss0}, 4'b1001);

        // Main vectors: T=2, W=16 -> nss low 66, 16 rises, ready back after 69 edges.
        for (int i = 0; i < 4; i++) begin
            run_xfer(0, vecs[i].cmd, vecs[i].miso, 0, r);
            check_xfer($sformatf("v%0d", i), r, 66, 16, 69, vecs[i].exp_mosi, vecs[i].exp_rsp);
            repeat (2) @(posedge clk);
            #1;
        end

        // rsp_data holds between transactions.
        repeat (5) @(posedge clk);
        #1;
        check("rsp_hold", r0_data, vecs[3].exp_rsp);

        // cmd_valid poked during SHIFT must be ignored.
        run_xfer(0, 16'hA55A, 16'h3C0F, 20, r);
        check_xfer("poke", r, 66, 16, 69, 16'hA55A, RB ? 16'h3C0F : 16'h0000);
        idle_hi = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (nss0 && c0_ready) idle_hi++;
        end
        check("poke_no_extra_xfer", idle_hi, 6);

        // Back-to-back with cmd_valid held high: nss high for exactly T+1 = 3 cycles.
        c0_valid = 1'b1; c0_data = 16'h0001;
        seg = 0; gap = 0; mw1 = '0; mw2 = '0; done = 1'b0;
        pnss = nss0; pck = ck0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk); #1;
            if (!nss0 && pnss) begin
                seg++;
                if (seg == 1) c0_data = 16'h8000;
                else c0_valid = 1'b0;
            end
            if (seg == 1 && nss0) gap++;
            if (ck0 && !pck) begin
                if (seg == 1) mw1 = {mw1[14:0], mosi0};
                else mw2 = {mw2[14:0], mosi0};
            end
            if (seg == 2 && c0_ready) done = 1'b1;
            pnss = nss0;
            pck  = ck0;
        end
        c0_valid = 1'b0;
        check("b2b_done", done, 1'b1);
        check("b2b_gap", gap, 3);
        check("b2b_word1", mw1, 16'h0001);
        check("b2b_word2", mw2, 16'h8000);
        repeat (2) @(posedge clk);

        // Reset in the middle of bit 7.
        #1;
        c0_valid = 1'b1; c0_data = 16'hA55A;
        @(posedge clk); #1;
        c0_valid = 1'b0;
        rises = 0; pck = ck0; hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (ck0 && !pck) rises++;
            pck = ck0;
            if (rises == 8) hit = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("rst_reached_bit7", hit, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_outputs", {nss0, ck0, mosi0, c0_ready, b0, r0_valid}, 6'b100100);
        check("rst_mid_rsp_data", r0_data, 16'h0000);
        rst = 1'b0;
        pulses = 0; idle_hi = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (r0_valid) pulses++;
            if (nss0) idle_hi++;
        end
        check("rst_no_rsp_valid", pulses, 0);
        check("rst_stays_idle", idle_hi, 80);

        // T=1, W=8: nss low 17, latency 19, rsp_data 0 unless readback is built in.
        run_xfer(1, 16'h00FF, 16'h00A5, 0, r);
        check_xfer("div1", r, 17, 8, 19, 16'h00FF, RB ? 16'h00A5 : 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
